// File: rtl/limit_counter_pkg.sv
//----------------------------------------------------------------------------
// Module : limit_counter_pkg
// Brief  : Controller state codes and helpers shared by the controller and
//          the limit counter.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package limit_counter_pkg;

  // Controller state codes driven onto the 'state' input
  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle
    S1 = 3'd1,  // run
    S2 = 3'd2   // done
  } ctrl_state_t;

  // Width needed to hold 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/limit_counter_if.sv
//----------------------------------------------------------------------------
// Module : limit_counter_if
// Brief  : Controller-to-counter bundle: control/sample inputs and the
//          counter status outputs.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface limit_counter_if
  import limit_counter_pkg::*;
#(
  parameter int DIN_W = 8,
  parameter int CNT_W = 16,
  parameter int SUM_W = 16
);

  logic              sreset;
  ctrl_state_t       state;
  logic [DIN_W-1:0]  din;
  logic              limit;
  logic [CNT_W-1:0]  count;
  logic [SUM_W-1:0]  sum;
  logic              ovf;
  logic              busy;

  // Controller side
  modport master (
    output sreset, state, din,
    input  limit, count, sum, ovf, busy
  );

  // Counter side
  modport slave (
    input  sreset, state, din,
    output limit, count, sum, ovf, busy
  );

endinterface

`default_nettype wire

// File: rtl/limit_counter_tick_gen.sv
//----------------------------------------------------------------------------
// Module : tick_gen
// Brief  : Prescaler. Counts 0..PRESCALE-1 while enabled and flags the last
//          count as a one-cycle tick; holds while disabled.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tick_gen
  import limit_counter_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  wire logic mclk,
  input  wire logic reset,
  input  wire logic en,
  output logic      tick
);

  localparam int              c_ps_w = cnt_width(PRESCALE);
  localparam logic [c_ps_w-1:0] c_last = c_ps_w'(PRESCALE - 1);

  logic [c_ps_w-1:0] r_cnt;
  logic              w_at_last;

  assign w_at_last = (r_cnt == c_last);
  assign tick      = en & w_at_last;

  // Advance and wrap while enabled; hold otherwise
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_at_last) r_cnt <= '0;
      else           r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/limit_counter.sv
//----------------------------------------------------------------------------
// Module : limit_counter
// Brief  : Counts prescaled ticks while the controller is in run, accumulates
//          a saturating sum of samples per tick and raises a sticky limit
//          flag once LIMIT ticks have been counted.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module limit_counter
  import limit_counter_pkg::*;
#(
  parameter int DIN_W    = 8,
  parameter int CNT_W    = 16,
  parameter int SUM_W    = 16,
  parameter int PRESCALE = 100,
  parameter int LIMIT    = 1000
) (
  input  wire logic       mclk,
  input  wire logic       reset,
  limit_counter_if.slave  bus
);

  // Internal sequencing; encoding is private to this block
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HIT   = 2'd2
  } fsm_t;

  localparam int               c_acc_w   = ((DIN_W > SUM_W) ? DIN_W : SUM_W) + 1;
  localparam logic [CNT_W-1:0] c_limit   = CNT_W'(LIMIT);
  localparam logic [SUM_W-1:0] c_sum_max = '1;

  fsm_t               r_fsm;
  logic [CNT_W-1:0]   r_count;
  logic [SUM_W-1:0]   r_sum;
  logic               r_ovf;
  logic               r_limit;
  logic               r_busy;

  logic               w_run;
  logic               w_tg_clr;
  logic               w_tg_en;
  logic               w_tick;
  logic [c_acc_w-1:0] w_acc;
  logic               w_sat;
  logic [SUM_W-1:0]   w_sum_next;
  logic [CNT_W-1:0]   w_count_inc;

  assign w_run = (bus.state == S1) && !bus.sreset;

  // Prescaler is held at zero outside COUNT and on any clear; inside COUNT
  // with run low (and no sreset) it simply stops, freezing progress.
  assign w_tg_clr = reset | bus.sreset | (r_fsm != COUNT);
  assign w_tg_en  = w_run & (r_fsm == COUNT);

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .mclk  (mclk),
    .reset (w_tg_clr),
    .en    (w_tg_en),
    .tick  (w_tick)
  );

  // Widened add exposes the carry used for saturation and the overflow flag
  assign w_acc       = c_acc_w'(r_sum) + c_acc_w'(bus.din);
  assign w_sat       = (w_acc > c_acc_w'(c_sum_max));
  assign w_sum_next  = w_sat ? c_sum_max : w_acc[SUM_W-1:0];
  assign w_count_inc = r_count + 1'b1;

  // Control FSM and registered datapath/status
  always_ff @(posedge mclk) begin
    if (reset || bus.sreset) begin
      r_fsm   <= IDLE;
      r_count <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_limit <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_run) begin
            r_fsm  <= COUNT;
            r_busy <= 1'b1;
          end
        end
        COUNT: begin
          // Only reachable with count==LIMIT when LIMIT is zero
          if (r_count == c_limit) begin
            r_fsm   <= HIT;
            r_busy  <= 1'b0;
            r_limit <= 1'b1;
          end else if (w_tick) begin
            r_count <= w_count_inc;
            r_sum   <= w_sum_next;
            r_ovf   <= r_ovf | w_sat;
            if (w_count_inc == c_limit) begin
              r_fsm   <= HIT;
              r_busy  <= 1'b0;
              r_limit <= 1'b1;
            end
          end
        end
        HIT: begin
          // Results held until sreset or reset
          r_fsm <= HIT;
        end
        default: begin
          r_fsm  <= IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.limit = r_limit;
  assign bus.count = r_count;
  assign bus.sum   = r_sum;
  assign bus.ovf   = r_ovf;
  assign bus.busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_limit_counter.sv
//----------------------------------------------------------------------------
// Module : tb_limit_counter
// Brief  : Directed self-checking bench for limit_counter (three configs).
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_limit_counter;
  import limit_counter_pkg::*;

  logic mclk = 1'b0;
  logic reset;

  always #5 mclk = ~mclk;

  // A: PRESCALE=4, LIMIT=5; B: SUM_W=8, PRESCALE=1, LIMIT=3; C: LIMIT=0
  limit_counter_if #(.DIN_W(8), .CNT_W(16), .SUM_W(16)) ifa ();
  limit_counter_if #(.DIN_W(8), .CNT_W(16), .SUM_W(8))  ifb ();
  limit_counter_if #(.DIN_W(8), .CNT_W(16), .SUM_W(16)) ifc ();

  limit_counter #(.DIN_W(8), .CNT_W(16), .SUM_W(16), .PRESCALE(4), .LIMIT(5)) u_dut_a (
    .mclk (mclk), .reset (reset), .bus (ifa)
  );
  limit_counter #(.DIN_W(8), .CNT_W(16), .SUM_W(8), .PRESCALE(1), .LIMIT(3)) u_dut_b (
    .mclk (mclk), .reset (reset), .bus (ifb)
  );
  limit_counter #(.DIN_W(8), .CNT_W(16), .SUM_W(16), .PRESCALE(4), .LIMIT(0)) u_dut_c (
    .mclk (mclk), .reset (reset), .bus (ifc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ifa.sreset = 1'b0; ifa.state = S0; ifa.din = '0;
    ifb.sreset = 1'b0; ifb.state = S0; ifb.din = '0;
    ifc.sreset = 1'b0; ifc.state = S0; ifc.din = '0;
    step(2);

    // Reset state
    chk("rst_limit", 32'(ifa.limit), 0);
    chk("rst_count", 32'(ifa.count), 0);
    chk("rst_sum",   32'(ifa.sum),   0);
    chk("rst_ovf",   32'(ifa.ovf),   0);
    chk("rst_busy",  32'(ifa.busy),  0);

    // Basic run: entry edge is edge 0, limit at edge 20
    reset = 1'b0; ifa.state = S1; ifa.din = 8'd3;
    step(1);
    chk("a_entry_busy",  32'(ifa.busy),  1);
    chk("a_entry_count", 32'(ifa.count), 0);
    step(19);
    chk("a_e19_limit", 32'(ifa.limit), 0);
    chk("a_e19_count", 32'(ifa.count), 4);
    chk("a_e19_sum",   32'(ifa.sum),   12);
    step(1);
    chk("a_e20_limit", 32'(ifa.limit), 1);
    chk("a_e20_count", 32'(ifa.count), 5);
    chk("a_e20_sum",   32'(ifa.sum),   15);
    chk("a_e20_ovf",   32'(ifa.ovf),   0);
    chk("a_e20_busy",  32'(ifa.busy),  0);
    step(8);
    chk("a_hit_count_hold", 32'(ifa.count), 5);
    chk("a_hit_limit_hold", 32'(ifa.limit), 1);

    // sreset clears HIT; then sreset coinciding with tick 2
    ifa.sreset = 1'b1;
    step(1);
    chk("a_sr_limit", 32'(ifa.limit), 0);
    chk("a_sr_count", 32'(ifa.count), 0);
    ifa.sreset = 1'b0;
    step(1);
    step(7);
    chk("a_pre_t2_count", 32'(ifa.count), 1);
    chk("a_pre_t2_sum",   32'(ifa.sum),   3);
    ifa.sreset = 1'b1;
    step(1);
    chk("a_t2sr_count", 32'(ifa.count), 0);
    chk("a_t2sr_sum",   32'(ifa.sum),   0);
    chk("a_t2sr_busy",  32'(ifa.busy),  0);
    ifa.sreset = 1'b0;
    step(1);
    chk("a_reentry_busy", 32'(ifa.busy), 1);
    step(19);
    chk("a_re19_limit", 32'(ifa.limit), 0);
    step(1);
    chk("a_re20_limit", 32'(ifa.limit), 1);
    chk("a_re20_count", 32'(ifa.count), 5);

    // Freeze mid-count with state=S0, then resume
    ifa.sreset = 1'b1;
    step(1);
    ifa.sreset = 1'b0; ifa.din = 8'd7;
    step(1);
    step(8);
    chk("a_fz_pre_count", 32'(ifa.count), 2);
    chk("a_fz_pre_sum",   32'(ifa.sum),   14);
    ifa.state = S0;
    step(10);
    chk("a_fz_count", 32'(ifa.count), 2);
    chk("a_fz_sum",   32'(ifa.sum),   14);
    chk("a_fz_busy",  32'(ifa.busy),  1);
    chk("a_fz_limit", 32'(ifa.limit), 0);
    ifa.state = S1;
    step(11);
    chk("a_rs11_count", 32'(ifa.count), 4);
    chk("a_rs11_limit", 32'(ifa.limit), 0);
    step(1);
    chk("a_rs12_limit", 32'(ifa.limit), 1);
    chk("a_rs12_count", 32'(ifa.count), 5);
    chk("a_rs12_sum",   32'(ifa.sum),   35);

    // reset + sreset with a tick due on the same edge
    ifa.sreset = 1'b1;
    step(1);
    ifa.sreset = 1'b0; ifa.din = 8'd2;
    step(1);
    step(7);
    chk("a_pre_rst_count", 32'(ifa.count), 1);
    reset = 1'b1; ifa.sreset = 1'b1;
    step(1);
    chk("a_rr_count", 32'(ifa.count), 0);
    chk("a_rr_sum",   32'(ifa.sum),   0);
    chk("a_rr_ovf",   32'(ifa.ovf),   0);
    chk("a_rr_limit", 32'(ifa.limit), 0);
    chk("a_rr_busy",  32'(ifa.busy),  0);
    reset = 1'b0; ifa.sreset = 1'b0;
    step(1);
    chk("a_restart_busy",  32'(ifa.busy),  1);
    chk("a_restart_count", 32'(ifa.count), 0);
    step(4);
    chk("a_restart_t1_count", 32'(ifa.count), 1);
    chk("a_restart_t1_sum",   32'(ifa.sum),   2);

    // Saturation (B) and LIMIT=0 (C) in parallel
    ifa.state = S0;
    ifb.state = S1; ifb.din = 8'd255;
    ifc.state = S1; ifc.din = 8'd9;
    step(1);
    chk("b_entry_busy",  32'(ifb.busy),  1);
    chk("c_entry_busy",  32'(ifc.busy),  1);
    chk("c_entry_limit", 32'(ifc.limit), 0);
    step(1);
    chk("b_t1_sum",   32'(ifb.sum),   255);
    chk("b_t1_ovf",   32'(ifb.ovf),   0);
    chk("b_t1_count", 32'(ifb.count), 1);
    chk("c_limit",    32'(ifc.limit), 1);
    chk("c_count",    32'(ifc.count), 0);
    chk("c_sum",      32'(ifc.sum),   0);
    chk("c_busy",     32'(ifc.busy),  0);
    step(1);
    chk("b_t2_sum",   32'(ifb.sum),   255);
    chk("b_t2_ovf",   32'(ifb.ovf),   1);
    chk("b_t2_count", 32'(ifb.count), 2);
    chk("b_t2_limit", 32'(ifb.limit), 0);
    step(1);
    chk("b_t3_limit", 32'(ifb.limit), 1);
    chk("b_t3_count", 32'(ifb.count), 3);
    chk("b_t3_busy",  32'(ifb.busy),  0);
    step(4);
    chk("c_hold_count", 32'(ifc.count), 0);
    chk("c_hold_limit", 32'(ifc.limit), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
